stopwatch_mode_ctrl: RTL and testbench

Parametrised run/stop/edit mode controller for the stopwatch datapath, sitting between the input distributor (command pulses) and the time counter / display blink logic. It generalises the two-state run/edit controller to N edit units of D digits each. It adds a STOP (paused, not editing) state, bidirectional unit navigation, an idle auto-exit timeout, and an internally generated blink phase. All outputs are registered Moore outputs.

---
 rtl/stopwatch_mode_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_stopwatch_mode_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mode_ctrl.sv
// Run/stop/edit mode controller for the stopwatch: tracks RUN/STOP/EDIT, the
// selected edit unit, the idle auto-exit timeout and the edit blink phase.
module stopwatch_mode_ctrl #(
  parameter int NUM_UNITS          = 2,
  parameter int DIGITS_PER_UNIT    = 2,
  parameter int BLINK_HALF_TICKS   = 250,
  parameter int EDIT_TIMEOUT_TICKS = 5000,
  localparam int UW = ($clog2(NUM_UNITS) > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int W  = NUM_UNITS * DIGITS_PER_UNIT
) (
  input  logic          iClk,
  input  logic          iRstn,
  input  logic          iTick,
  input  logic          iRunToggle,
  input  logic          iEditModeToggle,
  input  logic          iUnitNext,
  input  logic          iUnitPrev,
  input  logic          iEditActivity,
  output logic          oRun,
  output logic          oEditEn,
  output logic [UW-1:0] oEditUnit,
  output logic [W-1:0]  oBlinkMask,
  output logic [W-1:0]  oBlankMask,
  output logic          oEditExit,
  output logic          oTimeout
);

  localparam int BW = (BLINK_HALF_TICKS > 1) ? $clog2(BLINK_HALF_TICKS) : 1;
  localparam int TW = (EDIT_TIMEOUT_TICKS > 1) ? $clog2(EDIT_TIMEOUT_TICKS) : 1;

  localparam logic [BW-1:0] BLINK_LAST =
    BW'((BLINK_HALF_TICKS > 0) ? BLINK_HALF_TICKS - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST =
    TW'((EDIT_TIMEOUT_TICKS > 0) ? EDIT_TIMEOUT_TICKS - 1 : 0);
  localparam logic [UW-1:0] UNIT_LAST = UW'(NUM_UNITS - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_STOP = 2'd1,
    ST_EDIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ret_stop_q, ret_stop_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  logic          run_q, run_d;
  logic          edit_en_q, edit_en_d;
  logic [UW-1:0] edit_unit_q, edit_unit_d;
  logic [W-1:0]  blink_mask_q, blink_mask_d;
  logic [W-1:0]  blank_mask_q, blank_mask_d;
  logic          edit_exit_q, edit_exit_d;
  logic          timeout_q, timeout_d;

  logic nav_next, nav_prev, tmo_hit;

  // Unit 0 owns the leftmost (most significant) digit group.
  function automatic logic [W-1:0] unit_mask(input logic [UW-1:0] unit);
    logic [W-1:0] mask;
    mask = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (unit == UW'(k)) mask[W-1-k*DIGITS_PER_UNIT -: DIGITS_PER_UNIT] = '1;
    end
    return mask;
  endfunction

  // NOTE: every signal gets a default before any branch, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ret_stop_d  = ret_stop_q;
    unit_d      = unit_q;
    tmo_cnt_d   = tmo_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    timeout_d   = 1'b0;

    nav_next = iUnitNext & ~iUnitPrev;
    nav_prev = iUnitPrev & ~iUnitNext;
    // Activity in the tick cycle restarts the count instead of expiring it.
    tmo_hit  = (EDIT_TIMEOUT_TICKS != 0) && iTick && !iEditActivity &&
               (tmo_cnt_q == TMO_LAST);

    unique case (state_q)
      ST_RUN, ST_STOP: begin
        if (iEditModeToggle) begin
          state_d    = ST_EDIT;
          ret_stop_d = (state_q == ST_STOP);
          unit_d     = '0;
        end else if (iRunToggle) begin
          state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end
      end
      ST_EDIT: begin
        if (iEditModeToggle) begin
          state_d = ret_stop_q ? ST_STOP : ST_RUN;
        end else if (tmo_hit) begin
          state_d   = ret_stop_q ? ST_STOP : ST_RUN;
          timeout_d = 1'b1;
        end else begin
          if (nav_next) begin
            unit_d = (unit_q == UNIT_LAST) ? '0 : unit_q + UW'(1);
          end else if (nav_prev) begin
            unit_d = (unit_q == '0) ? UNIT_LAST : unit_q - UW'(1);
          end

          if (nav_next || nav_prev || iEditActivity) begin
            tmo_cnt_d   = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
          end else if (iTick) begin
            if (EDIT_TIMEOUT_TICKS != 0) tmo_cnt_d = tmo_cnt_q + TW'(1);
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              phase_d     = ~phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BW'(1);
            end
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Counters sit at zero outside EDIT, which also gives a clean start on entry.
    if (state_d != ST_EDIT) begin
      tmo_cnt_d   = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end

    run_d        = (state_d == ST_RUN);
    edit_en_d    = (state_d == ST_EDIT);
    edit_unit_d  = edit_en_d ? unit_d : '0;
    blink_mask_d = edit_en_d ? unit_mask(unit_d) : '0;
    blank_mask_d = phase_d ? blink_mask_d : '0;
    edit_exit_d  = (state_q == ST_EDIT) && (state_d != ST_EDIT);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q      <= ST_RUN;
      ret_stop_q   <= 1'b0;
      unit_q       <= '0;
      tmo_cnt_q    <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      run_q        <= 1'b1;
      edit_en_q    <= 1'b0;
      edit_unit_q  <= '0;
      blink_mask_q <= '0;
      blank_mask_q <= '0;
      edit_exit_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_stop_q   <= ret_stop_d;
      unit_q       <= unit_d;
      tmo_cnt_q    <= tmo_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      run_q        <= run_d;
      edit_en_q    <= edit_en_d;
      edit_unit_q  <= edit_unit_d;
      blink_mask_q <= blink_mask_d;
      blank_mask_q <= blank_mask_d;
      edit_exit_q  <= edit_exit_d;
      timeout_q    <= timeout_d;
    end
  end

  assign oRun       = run_q;
  assign oEditEn    = edit_en_q;
  assign oEditUnit  = edit_unit_q;
  assign oBlinkMask = blink_mask_q;
  assign oBlankMask = blank_mask_q;
  assign oEditExit  = edit_exit_q;
  assign oTimeout   = timeout_q;

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Bench for stopwatch_mode_ctrl: two differently parameterised instances share
// stimulus and are each compared every cycle against a behavioural model.
module tb_stopwatch_mode_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic tick, run_tgl, edit_tgl, unit_next, unit_prev, activity;

  always #5 clk = ~clk;

  // Instance a: 3 units x 2 digits, blink half-period 2, timeout 4.
  logic       a_run, a_edit_en, a_exit, a_tmo;
  logic [1:0] a_unit;
  logic [5:0] a_blink, a_blank;
  // Instance b: 2 units x 2 digits, blink half-period 3, timeout disabled.
  logic       b_run, b_edit_en, b_exit, b_tmo;
  logic [0:0] b_unit;
  logic [3:0] b_blink, b_blank;

  stopwatch_mode_ctrl #(
    .NUM_UNITS(3), .DIGITS_PER_UNIT(2), .BLINK_HALF_TICKS(2), .EDIT_TIMEOUT_TICKS(4)
  ) dut_a (
    .iClk(clk), .iRstn(rst_n), .iTick(tick), .iRunToggle(run_tgl),
    .iEditModeToggle(edit_tgl), .iUnitNext(unit_next), .iUnitPrev(unit_prev),
    .iEditActivity(activity), .oRun(a_run), .oEditEn(a_edit_en),
    .oEditUnit(a_unit), .oBlinkMask(a_blink), .oBlankMask(a_blank),
    .oEditExit(a_exit), .oTimeout(a_tmo)
  );

  stopwatch_mode_ctrl #(
    .NUM_UNITS(2), .DIGITS_PER_UNIT(2), .BLINK_HALF_TICKS(3), .EDIT_TIMEOUT_TICKS(0)
  ) dut_b (
    .iClk(clk), .iRstn(rst_n), .iTick(tick), .iRunToggle(run_tgl),
    .iEditModeToggle(edit_tgl), .iUnitNext(unit_next), .iUnitPrev(unit_prev),
    .iEditActivity(activity), .oRun(b_run), .oEditEn(b_edit_en),
    .oEditUnit(b_unit), .oBlinkMask(b_blink), .oBlankMask(b_blank),
    .oEditExit(b_exit), .oTimeout(b_tmo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0=RUN 1=STOP 2=EDIT; counts are ticks since last restart.
  localparam int M_RUN = 0, M_STOP = 1, M_EDIT = 2;
  int c_units[2] = '{3, 2};
  int c_dig[2]   = '{2, 2};
  int c_blink[2] = '{2, 3};
  int c_tmo[2]   = '{4, 0};

  int md[2], rs[2], un[2], idle[2], bl[2], ph[2], ex[2], to[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      md[m] = M_RUN; rs[m] = M_RUN; un[m] = 0;
      idle[m] = 0; bl[m] = 0; ph[m] = 0; ex[m] = 0; to[m] = 0;
    end
  endtask

  task automatic model_leave(input int m, input int by_timeout);
    md[m] = rs[m]; ex[m] = 1; to[m] = by_timeout;
    idle[m] = 0; bl[m] = 0; ph[m] = 0;
  endtask

  task automatic model_step(input int m, input bit et, input bit rt, input bit nx,
                            input bit pv, input bit act, input bit tk);
    bit nav;
    nav   = nx ^ pv;
    ex[m] = 0;
    to[m] = 0;
    if (md[m] != M_EDIT) begin
      if (et) begin
        rs[m] = md[m]; md[m] = M_EDIT; un[m] = 0;
        idle[m] = 0; bl[m] = 0; ph[m] = 0;
      end else if (rt) begin
        md[m] = (md[m] == M_RUN) ? M_STOP : M_RUN;
      end
    end else if (et) begin
      model_leave(m, 0);
    end else if (c_tmo[m] > 0 && tk && !act && idle[m] + 1 == c_tmo[m]) begin
      model_leave(m, 1);
    end else begin
      if (nav) un[m] = nx ? (un[m] + 1) % c_units[m] : (un[m] + c_units[m] - 1) % c_units[m];
      if (nav || act) begin
        idle[m] = 0; bl[m] = 0; ph[m] = 0;
      end else if (tk) begin
        idle[m]++;
        bl[m]++;
        if (bl[m] == c_blink[m]) begin
          bl[m] = 0;
          ph[m] = 1 - ph[m];
        end
      end
    end
  endtask

  function automatic int exp_mask(input int m);
    if (md[m] != M_EDIT) return 0;
    return ((1 << c_dig[m]) - 1) << ((c_units[m] - 1 - un[m]) * c_dig[m]);
  endfunction

  task automatic check_outputs(input int m);
    logic [31:0] g_run, g_en, g_unit, g_blink, g_blank, g_exit, g_tmo;
    string nm;
    if (m == 0) begin
      nm = "a";
      g_run = 32'(a_run); g_en = 32'(a_edit_en); g_unit = 32'(a_unit);
      g_blink = 32'(a_blink); g_blank = 32'(a_blank);
      g_exit = 32'(a_exit); g_tmo = 32'(a_tmo);
    end else begin
      nm = "b";
      g_run = 32'(b_run); g_en = 32'(b_edit_en); g_unit = 32'(b_unit);
      g_blink = 32'(b_blink); g_blank = 32'(b_blank);
      g_exit = 32'(b_exit); g_tmo = 32'(b_tmo);
    end
    check({nm, ".run"},     g_run,   32'(md[m] == M_RUN));
    check({nm, ".edit_en"}, g_en,    32'(md[m] == M_EDIT));
    check({nm, ".unit"},    g_unit,  (md[m] == M_EDIT) ? 32'(un[m]) : 32'd0);
    check({nm, ".blink"},   g_blink, 32'(exp_mask(m)));
    check({nm, ".blank"},   g_blank, (ph[m] != 0) ? 32'(exp_mask(m)) : 32'd0);
    check({nm, ".exit"},    g_exit,  32'(ex[m]));
    check({nm, ".timeout"}, g_tmo,   32'(to[m]));
  endtask

  // Called at a falling edge: drive, advance models, clock, compare.
  task automatic cycle(input bit et, input bit rt, input bit nx,
                       input bit pv, input bit act, input bit tk);
    edit_tgl = et; run_tgl = rt; unit_next = nx; unit_prev = pv;
    activity = act; tick = tk;
    model_step(0, et, rt, nx, pv, act, tk);
    model_step(1, et, rt, nx, pv, act, tk);
    @(negedge clk);
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic clear_inputs();
    edit_tgl = 1'b0; run_tgl = 1'b0; unit_next = 1'b0;
    unit_prev = 1'b0; activity = 1'b0; tick = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    do_reset();

    // Enter and leave EDIT from RUN.
    cycle(1, 0, 0, 0, 0, 0);
    check("a.entry_mask", 32'(a_blink), 32'h30);
    check("b.entry_mask", 32'(b_blink), 32'hC);
    cycle(1, 0, 0, 0, 0, 0);
    check("a.exit_pulse", 32'(a_exit), 32'd1);
    check("a.exit_not_timeout", 32'(a_tmo), 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    check("a.exit_one_cycle", 32'(a_exit), 32'd0);

    // EDIT entered from STOP returns to STOP.
    cycle(0, 1, 0, 0, 0, 0);
    check("a.stop", 32'(a_run), 32'd0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("a.back_to_stop", 32'(a_run), 32'd0);

    // Navigation with wrap on the 3-unit instance.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    check("a.nav1_mask", 32'(a_blink), 32'h0C);
    cycle(0, 0, 1, 0, 0, 0);
    check("a.nav2_mask", 32'(a_blink), 32'h03);
    cycle(0, 0, 1, 0, 0, 0);
    check("a.nav_wrap_mask", 32'(a_blink), 32'h30);
    cycle(0, 0, 0, 1, 0, 0);
    check("a.prev_wrap_unit", 32'(a_unit), 32'd2);
    cycle(0, 0, 1, 1, 0, 0);
    check("a.both_nav_unit", 32'(a_unit), 32'd2);
    cycle(0, 1, 0, 0, 0, 0);
    check("a.run_ignored_in_edit", 32'(a_edit_en), 32'd1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);

    // Blink phase, activity restart and idle timeout.
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("a.blank_tick1", 32'(a_blank), 32'h00);
    cycle(0, 0, 0, 0, 0, 1);
    check("a.blank_tick2", 32'(a_blank), 32'h30);
    cycle(0, 0, 0, 0, 1, 0);
    check("a.blank_after_activity", 32'(a_blank), 32'h00);
    repeat (3) cycle(0, 0, 0, 0, 0, 1);
    check("a.still_edit", 32'(a_edit_en), 32'd1);
    cycle(0, 0, 0, 0, 0, 1);
    check("a.timeout_exit", 32'(a_exit), 32'd1);
    check("a.timeout_flag", 32'(a_tmo), 32'd1);
    check("a.timeout_ret_run", 32'(a_run), 32'd1);

    // Activity coinciding with the third tick restarts the timeout.
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1);
    repeat (3) cycle(0, 0, 0, 0, 0, 1);
    check("a.no_early_timeout", 32'(a_edit_en), 32'd1);
    cycle(0, 0, 0, 0, 0, 1);
    check("a.late_timeout", 32'(a_tmo), 32'd1);

    // Both toggles in RUN: edit wins.
    do_reset();
    cycle(1, 1, 0, 0, 0, 0);
    check("a.edit_beats_run", 32'(a_edit_en), 32'd1);

    // Disabled timeout stays in EDIT; then reset mid-EDIT.
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    repeat (10000) cycle(0, 0, 0, 0, 0, 1);
    check("b.no_timeout", 32'(b_edit_en), 32'd1);
    do_reset();
    check("b.reset_no_exit", 32'(b_exit), 32'd0);
    check("b.reset_run", 32'(b_run), 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 60);
      if ($urandom_range(0, 999) < 3) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
